control_unit: RTL and testbench

//   Multicycle control FSM for the RV64I datapath. Consumes the fetched instruction and ULA flags.

---
 rtl/control_pkg.sv | 56 +++++
 rtl/branch_cond.sv | 21 ++
 rtl/control_unit.sv | 218 +++++++++++++++++++++
 tb/tb_control_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared constants for the RV64I multicycle control unit: opcodes, FSM states,
// immediate formats, ULA operation codes and PC / write-back mux selects.
package control_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_t;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_J = 3'd1;
    localparam logic [2:0] IMM_U = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_S = 3'd4;

    localparam logic [1:0] ULA_NAO     = 2'd0;
    localparam logic [1:0] ULA_SOMA    = 2'd1;
    localparam logic [1:0] ULA_SUBTRAI = 2'd2;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ULA   = 2'd2;

    localparam logic [1:0] WB_ULA  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_IMM  = 2'd3;

    function automatic logic opc_known(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_OP, OPC_OP_IMM,
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] imm_fmt(input logic [6:0] opc);
        case (opc)
            OPC_STORE:          return IMM_S;
            OPC_BRANCH:         return IMM_B;
            OPC_LUI, OPC_AUIPC: return IMM_U;
            OPC_JAL:            return IMM_J;
            default:            return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch resolution: funct3 selects which ULA flag (or its inverse) means taken.
module branch_cond (
    input  logic [2:0] funct3,
    input  logic       flag_igual,
    input  logic       flag_menor,
    input  logic       flag_maior_igual_u,
    output logic       taken
);
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = flag_igual;
            3'b001:  taken = ~flag_igual;
            3'b100:  taken = flag_menor;
            3'b101:  taken = ~flag_menor;
            3'b110:  taken = ~flag_maior_igual_u;
            3'b111:  taken = flag_maior_igual_u;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM for the RV64I datapath (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Build option ILLEGAL_TRAP_EN: unknown opcodes halt with illegal=1 instead of acting as NOPs.
module control_unit
    import control_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        flag_igual,
    input  logic        flag_menor,
    input  logic        flag_maior_igual_u,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_sel,
    output logic        mem_we,
    output logic        ir_load,
    output logic        pc_load,
    output logic [1:0]  pc_sel,
    output logic        WeR,
    output logic [1:0]  wb_sel,
    output logic [2:0]  select_imm,
    output logic        usa_imm,
    output logic [1:0]  soma_ou_subtrai,
    output logic        halted,
    output logic        bus_err,
    output logic        illegal
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             halted_reg;
    logic             bus_err_reg;

    logic [6:0] opcode;
    logic       known;
    logic       taken;
    logic [1:0] ula_op;
    logic       ula_imm;

    assign opcode = instr[6:0];
    assign known  = opc_known(opcode);

    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31], instr[29:15]};

    branch_cond u_branch_cond (
        .funct3             (instr[14:12]),
        .flag_igual         (flag_igual),
        .flag_menor         (flag_menor),
        .flag_maior_igual_u (flag_maior_igual_u),
        .taken              (taken)
    );

`ifdef ILLEGAL_TRAP_EN
    logic illegal_reg;
    assign illegal = illegal_reg & ~rst;
`else
    assign illegal = 1'b0;
`endif
    assign halted  = halted_reg & ~rst;
    assign bus_err = bus_err_reg & ~rst;

    // The counter only matters in FETCH/MEM; holding it at 0 elsewhere clears it on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_FETCH;
            cnt_reg     <= '0;
            halted_reg  <= 1'b0;
            bus_err_reg <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_FETCH, ST_MEM: begin
                    if (mem_ready) begin
                        cnt_reg <= '0;
                        if (state_reg == ST_FETCH)
                            state_reg <= ST_DECODE;
                        else if (opcode == OPC_STORE)
                            state_reg <= ST_FETCH;
                        else
                            state_reg <= ST_WB;
                    end else if (cnt_reg == CNT_MAX) begin
                        bus_err_reg <= 1'b1;
                        halted_reg  <= 1'b1;
                        state_reg   <= ST_HALT;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_DECODE: begin
                    cnt_reg <= '0;
                    if (known) begin
                        state_reg <= ST_EXEC;
                    end else begin
`ifdef ILLEGAL_TRAP_EN
                        illegal_reg <= 1'b1;
                        halted_reg  <= 1'b1;
                        state_reg   <= ST_HALT;
`else
                        state_reg   <= ST_WB;
`endif
                    end
                end
                ST_EXEC: begin
                    cnt_reg <= '0;
                    case (opcode)
                        OPC_LOAD, OPC_STORE: state_reg <= ST_MEM;
                        OPC_BRANCH:          state_reg <= ST_FETCH;
                        default:             state_reg <= ST_WB;
                    endcase
                end
                ST_WB: begin
                    cnt_reg   <= '0;
                    state_reg <= ST_FETCH;
                end
                default: begin
                    cnt_reg   <= '0;
                    state_reg <= ST_HALT;
                end
            endcase
        end
    end

    always_comb begin
        ula_op  = ULA_NAO;
        ula_imm = 1'b0;
        case (opcode)
            OPC_OP:     ula_op = instr[30] ? ULA_SUBTRAI : ULA_SOMA;
            OPC_BRANCH: ula_op = ULA_SUBTRAI;
            OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR, OPC_AUIPC: begin
                ula_op  = ULA_SOMA;
                ula_imm = 1'b1;
            end
            default: begin
                ula_op  = ULA_NAO;
                ula_imm = 1'b0;
            end
        endcase
    end

    always_comb begin
        mem_req         = 1'b0;
        mem_sel         = 1'b0;
        mem_we          = 1'b0;
        ir_load         = 1'b0;
        pc_load         = 1'b0;
        pc_sel          = PC_PLUS4;
        WeR             = 1'b0;
        wb_sel          = WB_ULA;
        select_imm      = IMM_I;
        usa_imm         = 1'b0;
        soma_ou_subtrai = ULA_NAO;
        case (state_reg)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_load = mem_ready;
            end
            ST_DECODE: select_imm = imm_fmt(opcode);
            ST_EXEC: begin
                select_imm      = imm_fmt(opcode);
                soma_ou_subtrai = ula_op;
                usa_imm         = ula_imm;
                if (opcode == OPC_BRANCH) begin
                    pc_load = 1'b1;
                    pc_sel  = taken ? PC_IMM : PC_PLUS4;
                end
            end
            ST_MEM: begin
                select_imm      = imm_fmt(opcode);
                soma_ou_subtrai = ula_op;
                usa_imm         = ula_imm;
                mem_req         = 1'b1;
                mem_sel         = 1'b1;
                mem_we          = (opcode == OPC_STORE);
                pc_load         = (opcode == OPC_STORE) && mem_ready;
            end
            ST_WB: begin
                select_imm      = imm_fmt(opcode);
                soma_ou_subtrai = ula_op;
                usa_imm         = ula_imm;
                pc_load         = 1'b1;
                WeR             = known && (instr[11:7] != 5'd0);
                case (opcode)
                    OPC_LOAD:          wb_sel = WB_MEM;
                    OPC_JAL, OPC_JALR: wb_sel = WB_PC4;
                    OPC_LUI:           wb_sel = WB_IMM;
                    default:           wb_sel = WB_ULA;
                endcase
                case (opcode)
                    OPC_JAL:  pc_sel = PC_IMM;
                    OPC_JALR: pc_sel = PC_ULA;
                    default:  pc_sel = PC_PLUS4;
                endcase
            end
            default: ;
        endcase
        if (rst) begin
            mem_req         = 1'b0;
            mem_sel         = 1'b0;
            mem_we          = 1'b0;
            ir_load         = 1'b0;
            pc_load         = 1'b0;
            pc_sel          = PC_PLUS4;
            WeR             = 1'b0;
            wb_sel          = WB_ULA;
            select_imm      = IMM_I;
            usa_imm         = 1'b0;
            soma_ou_subtrai = ULA_NAO;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes the expected control vector for
// each cycle, a negedge monitor pops and compares against the DUT outputs.
module tb_control_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        flag_igual, flag_menor, flag_maior_igual_u, mem_ready;
    logic        mem_req, mem_sel, mem_we, ir_load, pc_load, WeR, usa_imm;
    logic        halted, bus_err, illegal;
    logic [1:0]  pc_sel, wb_sel, soma_ou_subtrai;
    logic [2:0]  select_imm;

    control_unit dut (
        .clk(clk), .rst(rst), .instr(instr),
        .flag_igual(flag_igual), .flag_menor(flag_menor),
        .flag_maior_igual_u(flag_maior_igual_u), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we), .ir_load(ir_load),
        .pc_load(pc_load), .pc_sel(pc_sel), .WeR(WeR), .wb_sel(wb_sel),
        .select_imm(select_imm), .usa_imm(usa_imm), .soma_ou_subtrai(soma_ou_subtrai),
        .halted(halted), .bus_err(bus_err), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Observed vector layout, LSB first: illegal, bus_err, halted, soma[4:3], usa_imm,
    // select_imm[8:6], wb_sel[10:9], WeR, pc_sel[13:12], pc_load, ir_load, mem_we, mem_sel, mem_req
    localparam logic [18:0] ILL = 19'h1 << 0;
    localparam logic [18:0] BUS = 19'h1 << 1;
    localparam logic [18:0] HLT = 19'h1 << 2;
    localparam logic [18:0] S1  = 19'h1 << 3;
    localparam logic [18:0] S2  = 19'h2 << 3;
    localparam logic [18:0] USA = 19'h1 << 5;
    localparam logic [18:0] IJ  = 19'h1 << 6;
    localparam logic [18:0] IU  = 19'h2 << 6;
    localparam logic [18:0] IB  = 19'h3 << 6;
    localparam logic [18:0] IS  = 19'h4 << 6;
    localparam logic [18:0] WB1 = 19'h1 << 9;
    localparam logic [18:0] WB2 = 19'h2 << 9;
    localparam logic [18:0] WB3 = 19'h3 << 9;
    localparam logic [18:0] WER = 19'h1 << 11;
    localparam logic [18:0] PC1 = 19'h1 << 12;
    localparam logic [18:0] PC2 = 19'h2 << 12;
    localparam logic [18:0] PCL = 19'h1 << 14;
    localparam logic [18:0] IRL = 19'h1 << 15;
    localparam logic [18:0] WE  = 19'h1 << 16;
    localparam logic [18:0] SEL = 19'h1 << 17;
    localparam logic [18:0] REQ = 19'h1 << 18;

    typedef struct {
        int          cyc;
        string       name;
        logic [18:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_cur;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [18:0] obs;

    assign obs = {mem_req, mem_sel, mem_we, ir_load, pc_load, pc_sel, WeR, wb_sel,
                  select_imm, usa_imm, soma_ou_subtrai, halted, bus_err, illegal};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e_cur = sb.pop_front();
            total++;
            if (e_cur.cyc != cyc) begin
                bad++;
                $display("FAIL %s missed: cyc=%0d checked at %0d", e_cur.name, e_cur.cyc, cyc);
            end else if (obs !== e_cur.val) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%05h want=%05h", e_cur.name, cyc, obs, e_cur.val);
            end else begin
                $display("ok   %s cyc=%0d vec=%05h", e_cur.name, cyc, obs);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [18:0] v);
        exp_t e;
        e.cyc  = cyc;
        e.name = n;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic t(input string n, input logic [18:0] v);
        chk(n, v);
        step();
    endtask

    task automatic fetch(input string n, input logic [31:0] w);
        mem_ready = 1'b1;
        instr     = w;
        t({n, "_fetch"}, REQ | IRL);
        mem_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; instr = 32'h0; mem_ready = 1'b0;
        flag_igual = 1'b0; flag_menor = 1'b0; flag_maior_igual_u = 1'b0;
        step();
        t("rst_outs", 19'h0);
        rst = 1'b0;
        t("post_rst_fetch", REQ);

        fetch("addi", 32'h00500093);
        t("addi_dec", 19'h0);
        t("addi_exec", S1 | USA);
        t("addi_wb", WER | PCL | S1 | USA);

        fetch("beq_t", 32'h00208463);
        flag_igual = 1'b1;
        t("beq_t_dec", IB);
        t("beq_t_exec", PCL | PC1 | S2 | IB);
        flag_igual = 1'b0;
        fetch("beq_n", 32'h00208463);
        t("beq_n_dec", IB);
        t("beq_n_exec", PCL | S2 | IB);

        flag_maior_igual_u = 1'b1;
        fetch("bgeu", 32'h0020F463);
        t("bgeu_dec", IB);
        t("bgeu_exec", PCL | PC1 | S2 | IB);
        fetch("bltu", 32'h0020E463);
        t("bltu_dec", IB);
        t("bltu_exec", PCL | S2 | IB);
        flag_maior_igual_u = 1'b0;

        fetch("sd", 32'h0020B023);
        t("sd_dec", IS);
        t("sd_exec", S1 | USA | IS);
        for (int i = 0; i < 3; i++) t("sd_mem_wait", REQ | SEL | WE | S1 | USA | IS);
        mem_ready = 1'b1;
        t("sd_mem_done", REQ | SEL | WE | PCL | S1 | USA | IS);
        mem_ready = 1'b0;
        t("sd_next_fetch", REQ);

        fetch("ld", 32'h0000B183);
        t("ld_dec", 19'h0);
        t("ld_exec", S1 | USA);
        mem_ready = 1'b1;
        t("ld_mem", REQ | SEL | S1 | USA);
        mem_ready = 1'b0;
        t("ld_wb", WER | PCL | WB1 | S1 | USA);

        fetch("jal", 32'h010000EF);
        t("jal_dec", IJ);
        t("jal_exec", IJ);
        t("jal_wb", WER | PCL | WB2 | PC1 | IJ);

        fetch("jalr", 32'h000280E7);
        t("jalr_dec", 19'h0);
        t("jalr_exec", S1 | USA);
        t("jalr_wb", WER | PCL | WB2 | PC2 | S1 | USA);

        fetch("lui", 32'h123452B7);
        t("lui_dec", IU);
        t("lui_exec", IU);
        t("lui_wb", WER | PCL | WB3 | IU);

        fetch("add_x0", 32'h00208033);
        t("add_x0_dec", 19'h0);
        t("add_x0_exec", S1);
        t("add_x0_wb", PCL | S1);

        fetch("sub", 32'h402081B3);
        t("sub_dec", 19'h0);
        t("sub_exec", S2);
        t("sub_wb", WER | PCL | S2);

        // Ready arriving on the last permitted wait cycle must still complete the fetch.
        for (int i = 0; i < 15; i++) t("late_wait", REQ);
        fetch("late", 32'h00500093);
        t("late_dec", 19'h0);
        t("late_exec", S1 | USA);
        t("late_wb", WER | PCL | S1 | USA);

        fetch("rstmem", 32'h0000B183);
        t("rstmem_dec", 19'h0);
        t("rstmem_exec", S1 | USA);
        t("rstmem_wait1", REQ | SEL | S1 | USA);
        t("rstmem_wait2", REQ | SEL | S1 | USA);
        rst = 1'b1;
        t("rstmem_rst", 19'h0);
        rst = 1'b0;
        t("rstmem_fetch", REQ);

        fetch("ill", 32'h0000007F);
        t("ill_dec", 19'h0);
`ifdef ILLEGAL_TRAP_EN
        t("ill_halt", HLT | ILL);
        mem_ready = 1'b1;
        t("ill_hold", HLT | ILL);
        mem_ready = 1'b0;
`else
        t("ill_wb", PCL);
        t("ill_next", REQ);
`endif

        rst = 1'b1;
        t("pre_to_rst", 19'h0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) t("to_wait", REQ);
        for (int i = 0; i < 3; i++) begin
            mem_ready = i[0];
            instr     = 32'h00500093;
            t("to_halt", HLT | BUS);
        end
        mem_ready = 1'b0;
        rst = 1'b1;
        t("to_rst", 19'h0);
        rst = 1'b0;
        t("final_fetch", REQ);

        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
